// File: rtl/uart_rxfifo.sv
// Receive FIFO for the 6402-style UART: show-ahead byte queue with overrun
// flag, trigger-level interrupt and a character timeout paced by the 16x baud tick.
module uart_rxfifo #(
   parameter int DEPTH         = 16,
   parameter int TRIG          = 8,
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   baudclk,
   input  logic                   rxdone,
   input  logic [7:0]             rxdata,
   output logic [7:0]             rbr,
   output logic                   dr,
   input  logic                   drr,
   output logic                   oe,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   timeout,
   output logic                   rxint
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] TRIG_C  = CW'(TRIG);
   localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT_TICKS - 1);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [TW-1:0] timer_r;
   logic          oe_r;
   logic          timeout_r;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          overrun_s;

   // Transfer decode; a pop at full frees the slot the concurrent push needs.
   always_comb begin
      full_s    = (count_r == DEPTH_C);
      empty_s   = (count_r == {CW{1'b0}});
      push_s    = rxdone & (~full_s | drr);
      pop_s     = drr & ~empty_s;
      overrun_s = rxdone & full_s & ~drr;
   end

   // Storage array, deliberately not reset.
   always_ff @(posedge clock) begin
      if (push_s && !clear) begin
         mem_r[wr_ptr_r] <= rxdata;
      end
   end

   // Pointers, fill count, overrun flag and character-timeout timer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         timer_r   <= {TW{1'b0}};
         oe_r      <= 1'b0;
         timeout_r <= 1'b0;
      end else if (clear) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         timer_r   <= {TW{1'b0}};
         oe_r      <= overrun_s;
         timeout_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (overrun_s) begin
            oe_r <= 1'b1;
         end else if (drr) begin
            oe_r <= 1'b0;
         end
         // Timer runs only while data sits untouched; it parks at its last value.
         if (push_s || pop_s) begin
            timer_r   <= {TW{1'b0}};
            timeout_r <= 1'b0;
         end else if (empty_s) begin
            timer_r <= {TW{1'b0}};
         end else if (baudclk) begin
            if (timer_r == TMAX_C) begin
               timeout_r <= 1'b1;
            end else begin
               timer_r <= timer_r + TW'(1);
            end
         end
      end
   end

   // Output decode, from registers only.
   always_comb begin
      if (empty_s) begin
         rbr = 8'h00;
      end else begin
         rbr = mem_r[rd_ptr_r];
      end
      dr      = ~empty_s;
      full    = full_s;
      count   = count_r;
      oe      = oe_r;
      timeout = timeout_r;
      rxint   = (count_r >= TRIG_C) | timeout_r;
   end

endmodule

// File: tb/tb_uart_rxfifo.sv
// Self-checking bench for uart_rxfifo: directed test-plan scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_uart_rxfifo;

   localparam int DEPTH = 16;
   localparam int TRIG  = 8;
   localparam int TT    = 640;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       clear = 1'b0;
   logic       baudclk = 1'b0;
   logic       rxdone = 1'b0;
   logic [7:0] rxdata = 8'h00;
   logic [7:0] rbr;
   logic       dr;
   logic       drr = 1'b0;
   logic       oe;
   logic       full;
   logic [4:0] count;
   logic       timeout;
   logic       rxint;

   uart_rxfifo #(.DEPTH(DEPTH), .TRIG(TRIG), .TIMEOUT_TICKS(TT)) dut (
      .clock(clock), .reset_n(reset_n), .clear(clear), .baudclk(baudclk),
      .rxdone(rxdone), .rxdata(rxdata), .rbr(rbr), .dr(dr), .drr(drr),
      .oe(oe), .full(full), .count(count), .timeout(timeout), .rxint(rxint)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] q[$];
   bit         oe_m;
   bit         to_m;
   int         idle_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      oe_m = 1'b0;
      to_m = 1'b0;
      idle_m = 0;
   endtask

   task automatic model_step(input bit rxd, input logic [7:0] d, input bit rd,
                             input bit bclk, input bit clr);
      int  sz;
      bit  ovr, popped, pushed;
      sz  = q.size();
      ovr = rxd && (sz == DEPTH) && !rd;
      if (clr) begin
         q.delete();
         oe_m = ovr;
         to_m = 1'b0;
         idle_m = 0;
      end else begin
         popped = rd && (sz > 0);
         pushed = rxd && !ovr;
         if (popped) void'(q.pop_front());
         if (pushed) q.push_back(d);
         if (ovr) oe_m = 1'b1;
         else if (rd) oe_m = 1'b0;
         if (popped || pushed) begin
            idle_m = 0;
            to_m = 1'b0;
         end else if (sz == 0) begin
            idle_m = 0;
         end else if (bclk) begin
            if (idle_m < TT) idle_m++;
            if (idle_m == TT) to_m = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = q.size();
      check("count", 32'(count), 32'(sz));
      check("dr", 32'(dr), 32'(sz > 0));
      check("rbr", 32'(rbr), (sz > 0) ? 32'(q[0]) : 32'h0);
      check("full", 32'(full), 32'(sz == DEPTH));
      check("oe", 32'(oe), 32'(oe_m));
      check("timeout", 32'(timeout), 32'(to_m));
      check("rxint", 32'(rxint), 32'((sz >= TRIG) || to_m));
   endtask

   task automatic cycle(input bit rxd, input logic [7:0] d, input bit rd,
                        input bit bclk, input bit clr);
      rxdone = rxd; rxdata = d; drr = rd; baudclk = bclk; clear = clr;
      @(posedge clock);
      model_step(rxd, d, rd, bclk, clr);
      #1;
      rxdone = 1'b0; drr = 1'b0; baudclk = 1'b0; clear = 1'b0;
      check_outputs();
   endtask

   initial begin
      logic [7:0] last_pop;
      model_reset();
      #1;
      check_outputs();
      @(negedge clock);
      reset_n = 1'b1;

      // drr while empty
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("empty_drr_count", 32'(count), 32'h0);

      // order across pointer wrap, count kept at or below 3
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b1, 8'(i), (q.size() >= 3), 1'b0, 1'b0);
      end
      while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // full and overrun
      for (int i = 1; i <= 17; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         if (i == 16) check("full_at_16", 32'(full), 32'h1);
      end
      check("overrun_oe", 32'(oe), 32'h1);
      check("overrun_count", 32'(count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         check("overrun_order", 32'(rbr), 32'(i));
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         if (i == 1) check("drr_clears_oe", 32'(oe), 32'h0);
      end

      // simultaneous push and pop at full
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      check("simul_no_oe", 32'(oe), 32'h0);
      check("simul_count", 32'(count), 32'd16);
      last_pop = 8'h00;
      while (q.size() > 0) begin
         last_pop = rbr;
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      check("simul_last", 32'(last_pop), 32'hA5);

      // trigger level
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
      check("trig_below", 32'(rxint), 32'h0);
      cycle(1'b1, 8'h57, 1'b0, 1'b0, 1'b0);
      check("trig_at", 32'(rxint), 32'h1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("trig_pop", 32'(rxint), 32'h0);

      // character timeout, cleared once by pop and once by clear
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < TT - 1; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (i % 3 == 0) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         end
         check("timeout_639", 32'(timeout), 32'h0);
         cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         check("timeout_640", 32'(timeout), 32'h1);
         check("timeout_rxint", 32'(rxint), 32'h1);
         cycle(1'b0, 8'h00, (k == 0), 1'b0, (k == 1));
         check("timeout_clr", 32'(timeout), 32'h0);
      end

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 35,
               $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);
      end

      // asynchronous reset mid-traffic
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #2;
      model_reset();
      check_outputs();
      @(negedge clock);
      reset_n = 1'b1;
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
